// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb -- two-requester write arbiter in front of a synchronous FIFO.
//
// Requesters use valid/ready: a word moves when valid and ready are both high
// on a rising clk edge. Ready is only ever offered to the current owner, and
// only while the FIFO has room beyond the AF_MARGIN reserve. An accepted word
// reaches the FIFO one cycle later through a registered write port
// (fifo_w_en / fifo_data_in). Ownership rotates after BURST_LEN accepted words
// whenever the other requester is waiting, so neither side can be starved.
//
// Optional feature: define SFIFO_WR_ARB_STATS_EN to build the per-requester
// accepted-word counters (stat0_cnt / stat1_cnt); otherwise they read 0.
module sfifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int BURST_LEN  = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic [1:0]            grant,
  output logic [15:0]           stat0_cnt,
  output logic [15:0]           stat1_cnt,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  // beat only needs to reach BURST_LEN-1: it clears on the word that completes a burst
  localparam int BEAT_W = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] SPACE_LIMIT = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic              last_owner;  // 0 = req0 owned last, 1 = req1 owned last
  logic              space;
  logic              xfer0;
  logic              xfer1;

  // Room for one more word, keeping AF_MARGIN entries free for the write in flight
  assign space      = !fifo_full && (fifo_count < SPACE_LIMIT);
  assign req0_ready = (state == ST_OWN0) && space;
  assign req1_ready = (state == ST_OWN1) && space;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign state_dbg  = state;

  // Ownership FSM: grant is registered alongside the state it encodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 2'b00;
      beat       <= '0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          beat <= '0;
          // On a tie, the requester that did not own last goes first
          if (req0_valid && (!req1_valid || last_owner)) begin
            state      <= ST_OWN0;
            grant      <= 2'b01;
            last_owner <= 1'b0;
          end else if (req1_valid) begin
            state      <= ST_OWN1;
            grant      <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        ST_OWN0: begin
          if (!req0_valid) begin
            beat <= '0;
            if (req1_valid) begin
              state      <= ST_OWN1;
              grant      <= 2'b10;
              last_owner <= 1'b1;
            end else begin
              state <= ST_IDLE;
              grant <= 2'b00;
            end
          end else if (xfer0) begin
            // Burst length only matters on a cycle that actually moved a word
            if (beat == BEAT_LAST) begin
              beat <= '0;
              if (req1_valid) begin
                state      <= ST_OWN1;
                grant      <= 2'b10;
                last_owner <= 1'b1;
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        ST_OWN1: begin
          if (!req1_valid) begin
            beat <= '0;
            if (req0_valid) begin
              state      <= ST_OWN0;
              grant      <= 2'b01;
              last_owner <= 1'b0;
            end else begin
              state <= ST_IDLE;
              grant <= 2'b00;
            end
          end else if (xfer1) begin
            if (beat == BEAT_LAST) begin
              beat <= '0;
              if (req0_valid) begin
                state      <= ST_OWN0;
                grant      <= 2'b01;
                last_owner <= 1'b0;
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
          beat  <= '0;
        end
      endcase
    end
  end

  // Registered FIFO write port; data holds its last value between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_w_en    <= 1'b0;
      fifo_data_in <= '0;
    end else begin
      fifo_w_en <= xfer0 || xfer1;
      if (xfer0) begin
        fifo_data_in <= req0_data;
      end else if (xfer1) begin
        fifo_data_in <= req1_data;
      end
    end
  end

`ifdef SFIFO_WR_ARB_STATS_EN
  // Accepted-word counters, free-running with 16-bit wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_cnt <= 16'd0;
      stat1_cnt <= 16'd0;
    end else begin
      if (xfer0) stat0_cnt <= stat0_cnt + 16'd1;
      if (xfer1) stat1_cnt <= stat1_cnt + 16'd1;
    end
  end
`else
  assign stat0_cnt = 16'd0;
  assign stat1_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb -- self-checking bench for sfifo_wr_arb.
// Requester sources are word queues; the FIFO behind the arbiter is a queue.
// A transaction-level model predicts owner, readies and stats; a scoreboard
// (exp_q) checks every FIFO write against the predicted accepted-word order.
// Valid/ready: a word moves on a rising edge where valid && ready.
module tb_sfifo_wr_arb;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int BL    = 4;
  localparam int AFM   = 2;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = DEPTH - AFM;
`ifdef SFIFO_WR_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          v0, v1;
  logic [DW-1:0] d0, d1;
  logic          r0, r1;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic [1:0]    grant;
  logic [15:0]   stat0_cnt, stat1_cnt;
  logic [1:0]    state_dbg;

  sfifo_wr_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .grant(grant), .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- bench state ----------------
  int checks;
  int failures;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] src0_q[$];
  logic [DW-1:0] src1_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_log[$];
  int            acc_owner[$];
  bit gate0, gate1, rd_en;

  // reference model: owner -1 = nobody, 0 = req0, 1 = req1
  int            m_owner;
  int            m_run;
  int            m_last;
  bit            m_pend;
  logic [DW-1:0] m_hold;
  logic [15:0]   exp_s0, exp_s1;

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_last = 1; m_pend = 1'b0; m_hold = '0;
    exp_s0 = 16'd0; exp_s1 = 16'd0;
    exp_q.delete(); src0_q.delete(); src1_q.delete(); fifo_q.delete();
    wr_log.delete(); acc_owner.delete();
    gate0 = 1'b0; gate1 = 1'b0; rd_en = 1'b0;
    fifo_count = '0; fifo_full = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic tick();
    bit sp, e_r0, e_r1, t0, t1, vm, vo, tm;
    logic [1:0] e_grant;
    logic [DW-1:0] w;
    // write port observed against the model's pending word
    checks++;
    if (fifo_w_en !== m_pend) begin
      failures++;
      $display("FAIL w_en: got %0b expected %0b at %0t", fifo_w_en, m_pend, $time);
    end
    if (fifo_w_en === 1'b1) begin
      wr_log.push_back(fifo_data_in);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_data: unexpected write %0h", fifo_data_in);
      end else begin
        w = exp_q.pop_front();
        m_hold = w;
        checks++;
        if (fifo_data_in !== w) begin
          failures++;
          $display("FAIL wr_data: got %0h expected %0h at %0t", fifo_data_in, w, $time);
        end
      end
      checks++;
      if (fifo_q.size() >= DEPTH) begin
        failures++;
        $display("FAIL overflow: got write with %0d entries expected room", fifo_q.size());
      end else begin
        fifo_q.push_back(fifo_data_in);
      end
    end else begin
      checks++;
      if (fifo_data_in !== m_hold) begin
        failures++;
        $display("FAIL data_hold: got %0h expected %0h", fifo_data_in, m_hold);
      end
    end
    if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_count = (AW+1)'(fifo_q.size());
    fifo_full  = (fifo_q.size() == DEPTH);
    // drive requesters
    v0 = gate0 && (src0_q.size() > 0);
    v1 = gate1 && (src1_q.size() > 0);
    d0 = v0 ? src0_q[0] : DW'($urandom_range(0, 255));
    d1 = v1 ? src1_q[0] : DW'($urandom_range(0, 255));
    #1;
    sp   = (fifo_q.size() < DEPTH) && (fifo_q.size() < LIMIT);
    e_r0 = (m_owner == 0) && sp;
    e_r1 = (m_owner == 1) && sp;
    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    checks++;
    if (r0 !== e_r0) begin
      failures++;
      $display("FAIL ready0: got %0b expected %0b at %0t", r0, e_r0, $time);
    end
    checks++;
    if (r1 !== e_r1) begin
      failures++;
      $display("FAIL ready1: got %0b expected %0b at %0t", r1, e_r1, $time);
    end
    checks++;
    if (grant !== e_grant) begin
      failures++;
      $display("FAIL grant: got %b expected %b at %0t", grant, e_grant, $time);
    end
    checks++;
    if (stat0_cnt !== (STATS_ON ? exp_s0 : 16'd0) || stat1_cnt !== (STATS_ON ? exp_s1 : 16'd0)) begin
      failures++;
      $display("FAIL stats: got %0d/%0d expected %0d/%0d", stat0_cnt, stat1_cnt,
               STATS_ON ? exp_s0 : 16'd0, STATS_ON ? exp_s1 : 16'd0);
    end
    // transfers predicted by the model
    t0 = v0 && e_r0;
    t1 = v1 && e_r1;
    m_pend = t0 || t1;
    if (t0) begin exp_q.push_back(d0); acc_owner.push_back(0); exp_s0 = exp_s0 + 16'd1; end
    if (t1) begin exp_q.push_back(d1); acc_owner.push_back(1); exp_s1 = exp_s1 + 16'd1; end
    // sources follow the real handshake
    if (v0 && r0 === 1'b1) void'(src0_q.pop_front());
    if (v1 && r1 === 1'b1) void'(src1_q.pop_front());
    // ownership rules
    if (m_owner < 0) begin
      m_run = 0;
      if (v0 && v1) m_owner = (m_last == 1) ? 0 : 1;
      else if (v0)  m_owner = 0;
      else if (v1)  m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else begin
      vm = (m_owner == 0) ? v0 : v1;
      vo = (m_owner == 0) ? v1 : v0;
      tm = (m_owner == 0) ? t0 : t1;
      if (!vm) begin
        m_run = 0;
        m_owner = vo ? 1 - m_owner : -1;
        if (m_owner >= 0) m_last = m_owner;
      end else if (tm) begin
        m_run++;
        if (m_run == BL) begin
          m_run = 0;
          if (vo) begin m_owner = 1 - m_owner; m_last = m_owner; end
        end
      end
    end
    @(negedge clk);
  endtask

  // Run until sources are empty and nothing is in flight.
  task automatic drain(input int budget);
    int n;
    n = 0;
    rd_en = 1'b1;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || m_pend || m_owner >= 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    v0 = 1'b1; v1 = 1'b1; d0 = 8'hAA; d1 = 8'h55;
    @(negedge clk);
    #1;
    checks++;
    if (grant !== 2'b00 || state_dbg !== 2'b00) begin
      failures++; $display("FAIL rst_grant: got %b/%b expected 00/00", grant, state_dbg);
    end
    checks++;
    if (fifo_w_en !== 1'b0) begin failures++; $display("FAIL rst_wen: got %b expected 0", fifo_w_en); end
    checks++;
    if (fifo_data_in !== '0) begin failures++; $display("FAIL rst_data: got %0h expected 0", fifo_data_in); end
    checks++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b%b expected 00", r0, r1); end
    checks++;
    if (stat0_cnt !== 16'd0 || stat1_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat0_cnt, stat1_cnt);
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_tie_burst();
    int n;
    apply_reset();
    for (int i = 0; i < 8; i++) begin src0_q.push_back(DW'(8'h10 + i)); src1_q.push_back(DW'(8'h80 + i)); end
    gate0 = 1'b1; gate1 = 1'b1; rd_en = 1'b1;
    n = 0;
    while (acc_owner.size() < 12 && n < 60) begin tick(); n++; end
    checks++;
    if (acc_owner.size() < 12) begin
      failures++; $display("FAIL tie_timeout: got %0d words expected 12", acc_owner.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (acc_owner[i] != (i / BL) % 2) begin
          failures++; $display("FAIL tie_order: word %0d got req%0d expected req%0d", i, acc_owner[i], (i / BL) % 2);
        end
      end
    end
    drain(60);
  endtask

  task automatic test_single_stream();
    apply_reset();
    for (int i = 0; i < 10; i++) src0_q.push_back(DW'(i));
    gate0 = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (wr_log.size() != 10) begin
      failures++; $display("FAIL single_count: got %0d writes expected 10", wr_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wr_log[i] !== DW'(i)) begin
          failures++; $display("FAIL single_data: idx %0d got %0h expected %0h", i, wr_log[i], i);
        end
      end
    end
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL single_idle: got %b expected 00", grant); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 140; i++) src0_q.push_back(DW'(i));
    gate0 = 1'b1; rd_en = 1'b0;
    for (int i = 0; i < 160; i++) tick();
    checks++;
    if (fifo_q.size() != LIMIT) begin
      failures++; $display("FAIL bp_level: got %0d entries expected %0d", fifo_q.size(), LIMIT);
    end
    checks++;
    if (src0_q.size() != 140 - LIMIT) begin
      failures++; $display("FAIL bp_left: got %0d words expected %0d", src0_q.size(), 140 - LIMIT);
    end
    drain(400);
    checks++;
    if (wr_log.size() != 140) begin failures++; $display("FAIL bp_total: got %0d expected 140", wr_log.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 900; c++) begin
      if (src0_q.size() < 3) src0_q.push_back(DW'($urandom_range(0, 255)));
      if (src1_q.size() < 3) src1_q.push_back(DW'($urandom_range(0, 255)));
      gate0 = ($urandom_range(0, 3) != 0);
      gate1 = ($urandom_range(0, 3) != 0);
      rd_en = ($urandom_range(0, 1) == 1);
      if (c >= 300 && c < 500) rd_en = ($urandom_range(0, 7) == 0);
      tick();
    end
    gate0 = 1'b1; gate1 = 1'b1;
    drain(400);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    apply_reset();
    for (int i = 0; i < 8; i++) src1_q.push_back(DW'(8'hC0 + i));
    gate1 = 1'b1; rd_en = 1'b1;
    n = 0;
    while (acc_owner.size() < 2 && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL midrst_grant: got %b expected 00", grant); end
    checks++;
    if (fifo_w_en !== 1'b0) begin failures++; $display("FAIL midrst_wen: got %b expected 0", fifo_w_en); end
    checks++;
    if (r1 !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b expected 0", r1); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin src0_q.push_back(DW'(8'h20 + i)); src1_q.push_back(DW'(8'h30 + i)); end
    gate0 = 1'b1; gate1 = 1'b1; rd_en = 1'b1;
    n = 0;
    while (acc_owner.size() == 0 && n < 10) begin tick(); n++; end
    checks++;
    if (acc_owner.size() == 0 || acc_owner[0] != 0) begin
      failures++; $display("FAIL midrst_tie: got %0d words/first req%0d expected req0 first",
                           acc_owner.size(), acc_owner.size() ? acc_owner[0] : -1);
    end
    drain(60);
  endtask

  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 300; i++) src0_q.push_back(DW'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) src1_q.push_back(DW'($urandom_range(0, 255)));
    gate0 = 1'b1; gate1 = 1'b1;
    drain(800);
    checks++;
    if (stat0_cnt !== (STATS_ON ? 16'd300 : 16'd0)) begin
      failures++; $display("FAIL stat0: got %0d expected %0d", stat0_cnt, STATS_ON ? 300 : 0);
    end
    checks++;
    if (stat1_cnt !== (STATS_ON ? 16'd5 : 16'd0)) begin
      failures++; $display("FAIL stat1: got %0d expected %0d", stat1_cnt, STATS_ON ? 5 : 0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_tie_burst();
    test_single_stream();
    test_backpressure();
    test_random();
    test_reset_mid_burst();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
